// File: rtl/spi_ctrl_pkg.sv
// Shared constants for the SPI frame sequencer: FSM encoding, header defaults, frame width/type codes.
package spi_ctrl_pkg;

  localparam int FRAME_W = 16;

  localparam logic [7:0] HDR_SAMPLE_DFLT = 8'hA5;
  localparam logic [7:0] HDR_COEF_DFLT   = 8'hC3;

  localparam logic TYPE_SAMPLE = 1'b0;
  localparam logic TYPE_COEF   = 1'b1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] GET_HI = 3'd1;
  localparam logic [2:0] GET_LO = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] SKIP   = 3'd4;

endpackage

// File: rtl/sync_edge.sv
// N-flop synchroniser with a registered one-cycle rising-edge pulse.
// Latency: raw rise to pulse is STAGES+1 clocks; no backpressure (free-running).
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/spi_frame_ctrl.sv
// Parses synchronised SPI bytes (header, hi, lo) into typed 16-bit frames on a valid/ready output.
// Frame_Valid rises 1 clock after the last byte strobe; while held, further bytes are dropped with Overrun.
module spi_frame_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] HDR_SAMPLE  = HDR_SAMPLE_DFLT,
  parameter logic [7:0] HDR_COEF    = HDR_COEF_DFLT,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               SSPIF,
  input  logic [7:0]         Byte_In,
  input  logic               SS,
  output logic [FRAME_W-1:0] Frame_Data,
  output logic               Frame_Type,
  output logic               Frame_Valid,
  input  logic               Frame_Ready,
  output logic               Frame_Err,
  output logic               Overrun,
  output logic               Busy,
  output logic [FRAME_W-1:0] Frame_Count
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  // Compared before incrementing, so the error fires on the edge the count reaches TIMEOUT_CYC-1.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 2);

  logic               byte_stb;
  logic               ss_rise;
  logic [2:0]         state;
  logic [7:0]         byte_q;
  logic               type_q;
  logic [CW-1:0]      tcnt;
  logic [FRAME_W-1:0] frame_count;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sspif_sync (
    .clk   (Clk),
    .rst_n (Rst_n),
    .din   (SSPIF),
    .rise  (byte_stb)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .clk   (Clk),
    .rst_n (Rst_n),
    .din   (SS),
    .rise  (ss_rise)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      byte_q      <= '0;
      type_q      <= TYPE_SAMPLE;
      tcnt        <= '0;
      Frame_Data  <= '0;
      Frame_Type  <= TYPE_SAMPLE;
      Frame_Valid <= 1'b0;
      Frame_Err   <= 1'b0;
      Overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      Frame_Err <= 1'b0;
      Overrun   <= 1'b0;
      tcnt      <= '0;
      if (byte_stb) byte_q <= Byte_In;

      case (state)
        IDLE: begin
          if (byte_stb) begin
            if (ss_rise) begin
              Frame_Err <= 1'b1;
            end else if (Byte_In == HDR_SAMPLE || Byte_In == HDR_COEF) begin
              type_q <= (Byte_In == HDR_COEF) ? TYPE_COEF : TYPE_SAMPLE;
              state  <= GET_HI;
            end else begin
              Frame_Err <= 1'b1;
              state     <= SKIP;
            end
          end
        end

        GET_HI, GET_LO: begin
          // A byte arriving with deselect is consumed first; only a completing byte survives the abort.
          if (byte_stb) begin
            if (state == GET_LO) begin
              Frame_Data  <= {byte_q, Byte_In};
              Frame_Type  <= type_q;
              Frame_Valid <= 1'b1;
              state       <= HOLD;
            end else if (ss_rise) begin
              Frame_Err <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= GET_LO;
            end
          end else if (ss_rise || tcnt == TO_LAST) begin
            Frame_Err <= 1'b1;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end

        HOLD: begin
          if (byte_stb) Overrun <= 1'b1;
          if (Frame_Valid && Frame_Ready) begin
            Frame_Valid <= 1'b0;
            frame_count <= frame_count + FRAME_W'(1);
            state       <= IDLE;
          end
        end

        SKIP: begin
          if (ss_rise) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign Busy        = (state != IDLE);
  assign Frame_Count = frame_count;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl: directed scenarios plus randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_spi_frame_ctrl;

  localparam int         SYNC = 2;
  localparam int         TO   = 64;
  localparam logic [7:0] HS   = 8'hA5;
  localparam logic [7:0] HC   = 8'hC3;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        SSPIF = 1'b0;
  logic [7:0]  Byte_In = 8'h00;
  logic        SS = 1'b0;
  logic        Frame_Ready = 1'b0;
  logic [15:0] Frame_Data;
  logic        Frame_Type;
  logic        Frame_Valid;
  logic        Frame_Err;
  logic        Overrun;
  logic        Busy;
  logic [15:0] Frame_Count;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = 16'h0;

  spi_frame_ctrl #(
    .SYNC_STAGES (SYNC),
    .HDR_SAMPLE  (HS),
    .HDR_COEF    (HC),
    .TIMEOUT_CYC (TO)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .SSPIF       (SSPIF),
    .Byte_In     (Byte_In),
    .SS          (SS),
    .Frame_Data  (Frame_Data),
    .Frame_Type  (Frame_Type),
    .Frame_Valid (Frame_Valid),
    .Frame_Ready (Frame_Ready),
    .Frame_Err   (Frame_Err),
    .Overrun     (Overrun),
    .Busy        (Busy),
    .Frame_Count (Frame_Count)
  );

  always #5 Clk = ~Clk;

  // Inputs change on negedges; sampling 1ns later sees exactly what the next posedge will see.
  logic [16:0] acc_q[$];
  int          err_cnt = 0;
  int          ovr_cnt = 0;
  int          vld_cyc = 0;
  always @(negedge Clk) begin
    #1;
    if (Rst_n) begin
      if (Frame_Valid) vld_cyc++;
      if (Frame_Valid && Frame_Ready) acc_q.push_back({Frame_Type, Frame_Data});
      if (Frame_Err) err_cnt++;
      if (Overrun) ovr_cnt++;
    end
  end

  // Frame-level reference: a frame exists only for a known header; payload is hi*256+lo.
  function automatic bit model_frame(input logic [7:0] hdr, input logic [7:0] hi,
                                     input logic [7:0] lo, output logic [16:0] f);
    logic [15:0] payload;
    payload = 16'(hi * 16'd256 + lo);
    f = {(hdr == HC), payload};
    return (hdr == HS) || (hdr == HC);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge Clk);
    Byte_In = b;
    SSPIF   = 1'b1;
    repeat (4) @(negedge Clk);
    SSPIF = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic pulse_ss();
    @(negedge Clk);
    SS = 1'b1;
    repeat (4) @(negedge Clk);
    SS = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  function automatic logic [16:0] acc_at(input int idx);
    return (idx < acc_q.size()) ? acc_q[idx] : 17'h1FFFF;
  endfunction

  task automatic test_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    n_chk++;
    if ({Frame_Valid, Frame_Err, Overrun, Busy, Frame_Type} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, expected 00000", {Frame_Valid, Frame_Err, Overrun, Busy, Frame_Type});
    end
    n_chk++;
    if (Frame_Data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h, expected 0000", Frame_Data);
    end
    n_chk++;
    if (Frame_Count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_count: got %h, expected 0000", Frame_Count);
    end
    Rst_n = 1'b1;
    repeat (4) @(negedge Clk);
    n_chk++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b, expected 0", Busy);
    end
  endtask

  task automatic test_basic();
    int a0 = acc_q.size();
    int v0 = vld_cyc;
    int e0 = err_cnt;
    Frame_Ready = 1'b1;
    send_byte(HS); send_byte(8'h12); send_byte(8'h34);
    repeat (3) @(negedge Clk);
    exp_cnt = exp_cnt + 16'd1;
    n_chk++;
    if (acc_at(a0) !== {1'b0, 16'h1234} || acc_q.size() != a0 + 1) begin
      n_fail++;
      $display("FAIL basic_frame: got %h (n=%0d), expected 01234 (n=%0d)", acc_at(a0), acc_q.size(), a0 + 1);
    end
    n_chk++;
    if (vld_cyc - v0 != 1) begin
      n_fail++;
      $display("FAIL basic_valid_width: got %0d cycles, expected 1", vld_cyc - v0);
    end
    n_chk++;
    if (Frame_Count !== exp_cnt || err_cnt != e0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_status: got cnt=%h err=%0d busy=%b, expected cnt=%h err=%0d busy=0",
               Frame_Count, err_cnt - e0, Busy, exp_cnt, 0);
    end
  endtask

  task automatic test_backpressure();
    int o0;
    bit stable = 1'b1;
    int a0 = acc_q.size();
    Frame_Ready = 1'b0;
    send_byte(HC); send_byte(8'hBE); send_byte(8'hEF);
    n_chk++;
    if ({Frame_Valid, Busy, Frame_Type, Frame_Data} !== {1'b1, 1'b1, 1'b1, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL bp_hold: got vld=%b busy=%b type=%b data=%h, expected 1 1 1 beef",
               Frame_Valid, Busy, Frame_Type, Frame_Data);
    end
    o0 = ovr_cnt;
    send_byte(8'h5A);
    n_chk++;
    if (ovr_cnt - o0 != 1) begin
      n_fail++;
      $display("FAIL bp_overrun: got %0d pulses, expected 1", ovr_cnt - o0);
    end
    repeat (84) begin
      @(negedge Clk);
      if (!(Frame_Valid === 1'b1 && {Frame_Type, Frame_Data} === {1'b1, 16'hBEEF})) stable = 1'b0;
    end
    n_chk++;
    if (!stable) begin
      n_fail++;
      $display("FAIL bp_stable: got output change during hold, expected {1,beef} held");
    end
    Frame_Ready = 1'b1;
    @(negedge Clk);
    exp_cnt = exp_cnt + 16'd1;
    n_chk++;
    if (Frame_Valid !== 1'b0 || Frame_Count !== exp_cnt) begin
      n_fail++;
      $display("FAIL bp_accept: got vld=%b cnt=%h, expected vld=0 cnt=%h", Frame_Valid, Frame_Count, exp_cnt);
    end
    n_chk++;
    if (acc_at(a0) !== {1'b1, 16'hBEEF} || acc_q.size() != a0 + 1) begin
      n_fail++;
      $display("FAIL bp_frame: got %h (n=%0d), expected 1beef (n=%0d)", acc_at(a0), acc_q.size(), a0 + 1);
    end
  endtask

  task automatic test_bad_header();
    int e0 = err_cnt;
    int a0 = acc_q.size();
    send_byte(8'h7E);
    n_chk++;
    if (err_cnt - e0 != 1 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL badhdr_err: got err=%0d busy=%b, expected err=1 busy=1", err_cnt - e0, Busy);
    end
    send_byte(8'h11); send_byte(HS);
    n_chk++;
    if (err_cnt - e0 != 1 || acc_q.size() != a0 || Busy !== 1'b1 || Frame_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL badhdr_skip: got err=%0d frames=%0d busy=%b, expected err=1 frames=0 busy=1",
               err_cnt - e0, acc_q.size() - a0, Busy);
    end
    pulse_ss();
    n_chk++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL badhdr_release: got busy=%b, expected 0", Busy);
    end
    send_byte(HS); send_byte(8'h00); send_byte(8'h01);
    repeat (2) @(negedge Clk);
    exp_cnt = exp_cnt + 16'd1;
    n_chk++;
    if (acc_at(a0) !== {1'b0, 16'h0001} || Frame_Count !== exp_cnt) begin
      n_fail++;
      $display("FAIL badhdr_recover: got %h cnt=%h, expected 00001 cnt=%h", acc_at(a0), Frame_Count, exp_cnt);
    end
  endtask

  task automatic test_abort();
    int e0 = err_cnt;
    int a0 = acc_q.size();
    send_byte(HS); send_byte(8'h55);
    pulse_ss();
    n_chk++;
    if (err_cnt - e0 != 1 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_err: got err=%0d busy=%b, expected err=1 busy=0", err_cnt - e0, Busy);
    end
    n_chk++;
    if (acc_q.size() != a0 || Frame_Valid !== 1'b0 || Frame_Count !== exp_cnt) begin
      n_fail++;
      $display("FAIL abort_noframe: got frames=%0d vld=%b cnt=%h, expected 0 0 %h",
               acc_q.size() - a0, Frame_Valid, Frame_Count, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_q[$];
    logic [16:0] f;
    logic [7:0]  hdr, hi, lo;
    int          r;
    int          exp_err = 0;
    int          e0 = err_cnt;
    int          a0 = acc_q.size();
    for (int it = 0; it < 14; it++) begin
      r   = $urandom_range(0, 3);
      hdr = (r == 0) ? 8'($urandom) : ((r == 1) ? HC : HS);
      hi  = 8'($urandom);
      lo  = 8'($urandom);
      if (model_frame(hdr, hi, lo, f)) begin
        exp_q.push_back(f);
        exp_cnt = exp_cnt + 16'd1;
        Frame_Ready = 1'($urandom_range(0, 1));
        send_byte(hdr); send_byte(hi); send_byte(lo);
        if (!Frame_Ready) begin
          repeat ($urandom_range(0, 20)) @(negedge Clk);
          Frame_Ready = 1'b1;
          @(negedge Clk);
        end
      end else begin
        exp_err++;
        send_byte(hdr);
        repeat ($urandom_range(0, 2)) send_byte(8'($urandom));
        pulse_ss();
      end
    end
    repeat (4) @(negedge Clk);
    n_chk++;
    if (acc_q.size() - a0 != exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d frames, expected %0d", acc_q.size() - a0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (acc_at(a0 + i) !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_frame[%0d]: got %h, expected %h", i, acc_at(a0 + i), exp_q[i]);
      end
    end
    n_chk++;
    if (err_cnt - e0 != exp_err || Frame_Count !== exp_cnt) begin
      n_fail++;
      $display("FAIL b2b_status: got err=%0d cnt=%h, expected err=%0d cnt=%h",
               err_cnt - e0, Frame_Count, exp_err, exp_cnt);
    end
  endtask

  task automatic test_timeout();
    int e0 = err_cnt;
    int first = -1;
    logic busy_pre = 1'b0;
    // Header is taken on edge SYNC+2; the error registers TO-1 edges later.
    int exp_first = SYNC + 2 + (TO - 1);
    @(negedge Clk);
    Byte_In = HS;
    SSPIF   = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge Clk);
      if (i == 4) SSPIF = 1'b0;
      if (i == exp_first - 1) busy_pre = Busy;
      if (Frame_Err === 1'b1 && first < 0) first = i;
    end
    n_chk++;
    if (first != exp_first) begin
      n_fail++;
      $display("FAIL timeout_cycle: got err at edge %0d, expected %0d", first, exp_first);
    end
    n_chk++;
    if (err_cnt - e0 != 1 || busy_pre !== 1'b1 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_status: got err=%0d busy_pre=%b busy=%b, expected 1 1 0",
               err_cnt - e0, busy_pre, Busy);
    end
  endtask

  task automatic test_reset_mid();
    send_byte(HC); send_byte(8'hDE); send_byte(8'hAD);
    exp_cnt = exp_cnt + 16'd1;
    send_byte(HS); send_byte(8'h77);
    @(negedge Clk);
    n_chk++;
    if (Busy !== 1'b1 || Frame_Data !== 16'hDEAD || Frame_Count !== exp_cnt) begin
      n_fail++;
      $display("FAIL rstmid_pre: got busy=%b data=%h cnt=%h, expected 1 dead %h", Busy, Frame_Data, Frame_Count, exp_cnt);
    end
    #2 Rst_n = 1'b0;
    #1;
    n_chk++;
    if ({Frame_Valid, Frame_Err, Overrun, Busy, Frame_Type, Frame_Data, Frame_Count} !== 37'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got vld=%b err=%b ovr=%b busy=%b type=%b data=%h cnt=%h, expected all 0",
               Frame_Valid, Frame_Err, Overrun, Busy, Frame_Type, Frame_Data, Frame_Count);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    exp_cnt = 16'h0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_wrap();
    int a0 = acc_q.size();
    force dut.frame_count = 16'hFFFF;
    @(negedge Clk);
    release dut.frame_count;
    exp_cnt = 16'hFFFF;
    Frame_Ready = 1'b1;
    send_byte(HC); send_byte(8'h0F); send_byte(8'hF0);
    repeat (2) @(negedge Clk);
    exp_cnt = exp_cnt + 16'd1;
    n_chk++;
    if (Frame_Count !== exp_cnt) begin
      n_fail++;
      $display("FAIL wrap_count: got %h, expected %h", Frame_Count, exp_cnt);
    end
    n_chk++;
    if (acc_at(a0) !== {1'b1, 16'h0FF0}) begin
      n_fail++;
      $display("FAIL wrap_frame: got %h, expected 10ff0", acc_at(a0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish after 50000 cycles, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bad_header();
    test_abort();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
- Sequences the SPI slave byte stream into typed 16-bit frames for the ANC datapath.
- Runs on the system clock Clk.
- Synchronises the slave's SSPIF byte-complete strobe and SS select line, then parses header/data bytes with an FSM.
- Presents each completed frame (noise sample or filter coefficient) on a valid/ready handshake, with error, overrun and timeout reporting.

Parameters:
- SYNC_STAGES, 2, flops in the SSPIF/SS synchronisers (min 2).
- HDR_SAMPLE, 8'hA5, header byte for a sample frame.
- HDR_COEF, 8'hC3, header byte for a coefficient frame.
- TIMEOUT_CYC, 4096, max Clk cycles between bytes inside a frame.

Ports:
- Clk  in  1  system clock; must be at least 8x the SCK rate.
- Rst_n  in  1  asynchronous, active-low reset.
- SSPIF  in  1  byte-complete flag from the SPI slave (SCK domain, level).
- Byte_In  in  8  received byte from the slave; bit7 = first bit shifted in; stable for 8 SCK periods after SSPIF rises.
- SS  in  1  slave select from the SPI bus, active low (SCK/external domain).
- Frame_Data  out  16  assembled payload, MSB byte first on the wire.
- Frame_Type  out  1  0 = sample, 1 = coefficient.
- Frame_Valid  out  1  frame available.
- Frame_Ready  in  1  consumer accepts the frame.
- Frame_Err  out  1  one-cycle pulse: bad header, SS abort or timeout.
- Overrun  out  1  one-cycle pulse: byte dropped while in HOLD.
- Busy  out  1  high in every state except IDLE.
- Frame_Count  out  16  completed-and-accepted frames; wraps 16'hFFFF -> 0.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; synchronisers, timeout counter and byte registers cleared. Reset may assert mid-frame and discards any partial frame.
- Synchronisation:
  - SSPIF and SS each pass through SYNC_STAGES flops.
  - byte_stb = rising edge of synced SSPIF, one cycle wide.
  - Byte_In is captured into a register on byte_stb; no separate synchroniser is needed because Byte_In is quasi-static.
  - ss_rise = rising edge of synced SS (deselect).
  - Latency from raw SSPIF rise to byte_stb is SYNC_STAGES+1 Clk cycles.
- FSM states: IDLE, GET_HI, GET_LO, HOLD, SKIP.
  - IDLE:
    - byte_stb with HDR_SAMPLE or HDR_COEF -> latch type, go to GET_HI.
    - byte_stb with any other value -> Frame_Err pulse, go to SKIP.
  - GET_HI: byte_stb -> hi byte stored, go to GET_LO.
  - GET_LO: byte_stb -> Frame_Data = {hi, byte}; Frame_Valid=1 on the next cycle; go to HOLD.
  - HOLD:
    - Frame_Valid && Frame_Ready -> Frame_Valid=0, Frame_Count++, go to IDLE.
    - byte_stb in HOLD -> byte discarded, Overrun pulse, stay in HOLD.
    - Frame_Data and Frame_Type are held stable while Valid is high.
  - SKIP: ignore bytes; ss_rise -> IDLE.
- SS abort: ss_rise in GET_HI or GET_LO -> Frame_Err pulse, go to IDLE. ss_rise in IDLE or HOLD has no effect.
- Simultaneous byte_stb and ss_rise: the byte is processed first.
  - If that byte completes the frame (GET_LO): the frame is valid and there is no error.
  - Otherwise: Frame_Err pulse, go to IDLE.
- Timeout:
  - The counter runs in GET_HI/GET_LO and clears on each byte_stb.
  - Reaching TIMEOUT_CYC-1 -> Frame_Err pulse, go to IDLE.
  - The counter is held at 0 in all other states.
- Frame_Err and Overrun are never asserted for more than one cycle per event.

Decomposition:
- Package spi_ctrl_pkg holds:
  - FSM state encoding (localparams IDLE..SKIP).
  - HDR_SAMPLE/HDR_COEF defaults.
  - FRAME_W = 16 and the TYPE_SAMPLE/TYPE_COEF constants.
- One sub-module, sync_edge: an N-stage synchroniser with rising-edge pulse output. It is instantiated for SSPIF and SS.

Test Plan:
- Send A5, 12, 34 with Frame_Ready=1 -> Frame_Valid high 1 cycle, Frame_Data=16'h1234, Frame_Type=0, Frame_Count=1.
- Send C3, BE, EF with Frame_Ready=0; 100 cycles later raise Ready -> data 16'hBEEF, Type=1 held stable, accepted on the Ready cycle. A 4th byte sent while in HOLD -> Overrun pulse, output unchanged.
- Send header 7E -> Frame_Err pulse; following bytes 11, 22 are ignored until SS rises; then A5, 00, 01 -> Frame_Data=16'h0001.
- Send A5, 55, then raise SS -> Frame_Err pulse, FSM in IDLE, no Frame_Valid, Frame_Count unchanged.
- With TIMEOUT_CYC=64, send A5 and then stall -> Frame_Err at cycle 63 after byte_stb, Busy falls.
- Force Frame_Count=16'hFFFF and complete a frame -> Frame_Count=0. Assert Rst_n low mid GET_LO -> all outputs 0 immediately.
